// File: rtl/swivm_memarb.sv
// swivm_memarb: two-port memory arbiter with a registered memory command,
// round-robin or port-0 priority with anti-starvation.
module swivm_memarb #(
  parameter int FIXED_PRI    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic [15:0] i_addr0,
  input  logic [31:0] i_wdata0,
  input  logic [1:0]  i_size0,
  input  logic        i_we0,
  input  logic        i_req1,
  input  logic [15:0] i_addr1,
  input  logic [31:0] i_wdata1,
  input  logic [1:0]  i_size1,
  input  logic        i_we1,
  output logic        o_ack0,
  output logic [31:0] o_rdata0,
  output logic        o_ack1,
  output logic [31:0] o_rdata1,
  output logic [15:0] o_mem_addr,
  output logic [31:0] o_mem_wrdata,
  output logic [1:0]  o_mem_size,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rddata,
  output logic        o_busy,
  output logic        o_owner
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic       last;
  logic [2:0] starve;
  logic       win;
  // win=1 selects port 1; a lone requester always wins
  always_comb begin
    win = (i_req0 & i_req1)
        ? ((FIXED_PRI != 0) ? (starve == 3'(STARVE_LIMIT)) : ~last)
        : i_req1;
  end
  assign o_busy = (state == ACCESS) || (state == DONE);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      last         <= 1'b1;
      starve       <= 3'd0;
      o_ack0       <= 1'b0;
      o_ack1       <= 1'b0;
      o_rdata0     <= 32'd0;
      o_rdata1     <= 32'd0;
      o_mem_addr   <= 16'd0;
      o_mem_wrdata <= 32'd0;
      o_mem_size   <= 2'b11;
      o_mem_we     <= 1'b1;
      o_owner      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          starve <= (!i_req1 || win) ? 3'd0 : starve + 3'd1;
          if (i_req0 || i_req1) begin
            o_mem_addr   <= win ? i_addr1  : i_addr0;
            o_mem_wrdata <= win ? i_wdata1 : i_wdata0;
            o_mem_size   <= win ? i_size1  : i_size0;
            o_mem_we     <= win ? i_we1    : i_we0;
            o_owner      <= win;
            last         <= win;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (o_mem_we && o_owner)  o_rdata1 <= i_mem_rddata;
          if (o_mem_we && !o_owner) o_rdata0 <= i_mem_rddata;
          o_ack0   <= ~o_owner;
          o_ack1   <= o_owner;
          o_mem_we <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          o_ack0 <= 1'b0;
          o_ack1 <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_swivm_memarb.sv
// tb_swivm_memarb: directed checks of a round-robin arbiter (a) and a
// fixed-priority one (b) driven by the same port stimulus.
module tb_swivm_memarb;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 1, we1 = 1;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic [1:0]  size0 = 2'b11, size1 = 2'b11;
  logic        ack0_a, ack1_a, ack0_b, ack1_b;
  logic [31:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  logic [15:0] maddr_a, maddr_b;
  logic [31:0] mwr_a, mwr_b, mrd_a, mrd_b;
  logic [1:0]  msize_a, msize_b;
  logic        mwe_a, mwe_b, busy_a, busy_b, owner_a, owner_b;
  int n_vec = 0, n_bad = 0;

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_f(input logic [15:0] a);
    return (a == 16'h0100) ? 32'hDEADBEEF : {a, ~a};
  endfunction
  assign mrd_a = mem_f(maddr_a);
  assign mrd_b = mem_f(maddr_b);

  swivm_memarb #(.FIXED_PRI(0), .STARVE_LIMIT(4)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(req0), .i_addr0(addr0), .i_wdata0(wdata0), .i_size0(size0), .i_we0(we0),
    .i_req1(req1), .i_addr1(addr1), .i_wdata1(wdata1), .i_size1(size1), .i_we1(we1),
    .o_ack0(ack0_a), .o_rdata0(rdata0_a), .o_ack1(ack1_a), .o_rdata1(rdata1_a),
    .o_mem_addr(maddr_a), .o_mem_wrdata(mwr_a), .o_mem_size(msize_a), .o_mem_we(mwe_a),
    .i_mem_rddata(mrd_a), .o_busy(busy_a), .o_owner(owner_a));

  swivm_memarb #(.FIXED_PRI(1), .STARVE_LIMIT(4)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(req0), .i_addr0(addr0), .i_wdata0(wdata0), .i_size0(size0), .i_we0(we0),
    .i_req1(req1), .i_addr1(addr1), .i_wdata1(wdata1), .i_size1(size1), .i_we1(we1),
    .o_ack0(ack0_b), .o_rdata0(rdata0_b), .o_ack1(ack1_b), .o_rdata1(rdata1_b),
    .o_mem_addr(maddr_b), .o_mem_wrdata(mwr_b), .o_mem_size(msize_b), .o_mem_we(mwe_b),
    .i_mem_rddata(mrd_b), .o_busy(busy_b), .o_owner(owner_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    req0 = 0; req1 = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_acks", {ack1_a, ack0_a}, 2'b00);
    chk("rst_rdata0", rdata0_a, 32'd0);
    chk("rst_maddr", maddr_a, 16'd0);
    chk("rst_msize", msize_a, 2'b11);
    chk("rst_mwe", mwe_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_owner", owner_a, 1'b0);

    // single p0 read of 0x0100
    req0 = 1; we0 = 1; addr0 = 16'h0100; size0 = 2'b11;
    @(negedge i_clk);
    chk("rd_busy", busy_a, 1'b1);
    chk("rd_maddr", maddr_a, 16'h0100);
    chk("rd_mwe", mwe_a, 1'b1);
    chk("rd_owner", owner_a, 1'b0);
    @(negedge i_clk);
    chk("rd_acks", {ack1_a, ack0_a}, 2'b01);
    chk("rd_rdata0", rdata0_a, 32'hDEADBEEF);
    req0 = 0;
    @(negedge i_clk);
    chk("rd_ack_end", {ack1_a, ack0_a}, 2'b00);
    chk("rd_idle", busy_a, 1'b0);

    // single p1 write of 0x12345678 to 0x0200, byte
    req1 = 1; we1 = 0; addr1 = 16'h0200; wdata1 = 32'h12345678; size1 = 2'b00;
    @(negedge i_clk);
    chk("wr_mwe", mwe_a, 1'b0);
    chk("wr_maddr", maddr_a, 16'h0200);
    chk("wr_msize", msize_a, 2'b00);
    chk("wr_wdata", mwr_a, 32'h12345678);
    chk("wr_owner", owner_a, 1'b1);
    @(negedge i_clk);
    chk("wr_mwe_end", mwe_a, 1'b1);
    chk("wr_acks", {ack1_a, ack0_a}, 2'b10);
    chk("wr_rdata1", rdata1_a, 32'd0);
    req1 = 0;
    @(negedge i_clk);

    // continuous tie: a alternates, b grants p0 x4 then p1
    do_reset();
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = 16'h0010; addr1 = 16'h0020; size0 = 2'b11; size1 = 2'b11;
    for (int n = 1; n <= 30; n++) begin
      @(negedge i_clk);
      if (n <= 12)
        chk($sformatf("rr_acks_%0d", n), {ack1_a, ack0_a},
            (n % 3 == 2) ? (((n / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk($sformatf("fp_acks_%0d", n), {ack1_b, ack0_b},
          (n % 3 == 2) ? (((n / 3) % 5 == 4) ? 2'b10 : 2'b01) : 2'b00);
    end
    chk("fp_rdata1", rdata1_b, 32'h0020FFDF);
    req0 = 0; req1 = 0;

    // reset asserted during a p0 write
    do_reset();
    req0 = 1; we0 = 0; addr0 = 16'h0040; wdata0 = 32'hCAFEF00D; size0 = 2'b10;
    @(negedge i_clk);
    chk("rw_mwe", mwe_a, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rw_mwe_async", mwe_a, 1'b1);
    chk("rw_busy_async", busy_a, 1'b0);
    chk("rw_ack_async", ack0_a, 1'b0);
    req1 = 1; we1 = 1; addr1 = 16'h0050;
    @(negedge i_clk);
    chk("rw_ack_held", {ack1_a, ack0_a}, 2'b00);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rw_owner", owner_a, 1'b0);
    chk("rw_mwe2", mwe_a, 1'b0);
    @(negedge i_clk);
    chk("rw_acks", {ack1_a, ack0_a}, 2'b01);
    req0 = 0; req1 = 0;

    // back-to-back p0 reads, second with size 01
    req0 = 1; we0 = 1; addr0 = 16'h0300; size0 = 2'b11;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("bb_maddr1", maddr_a, 16'h0300);
    @(negedge i_clk);
    chk("bb_ack1", {ack1_a, ack0_a}, 2'b01);
    chk("bb_rdata1", rdata0_a, 32'h0300FCFF);
    addr0 = 16'h0304; size0 = 2'b01;
    @(negedge i_clk);
    chk("bb_gap", {ack1_a, ack0_a}, 2'b00);
    @(negedge i_clk);
    chk("bb_maddr2", maddr_a, 16'h0304);
    chk("bb_msize2", msize_a, 2'b01);
    @(negedge i_clk);
    chk("bb_ack2", {ack1_a, ack0_a}, 2'b01);
    chk("bb_rdata2", rdata0_a, 32'h0304FCFB);
    req0 = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge i_clk);
      chk($sformatf("bb_quiet_%0d", n), {ack1_a, ack0_a, busy_a}, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/swivm_memarb.md
SWIVM_MEMARB -- requirements
Module: swivm_memarb

Interface
REQ-001 Parameter FIXED_PRI, default 0, selects the arbitration policy: 0 = round-robin, 1 = port 0 priority with anti-starvation.
REQ-002 Parameter STARVE_LIMIT, default 4, is the number of consecutive port-0 grants allowed while port 1 waits (used only when FIXED_PRI=1).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 i_clk  in  1  clock; all state changes on the rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_reqN  in  1  port N request, N = 0,1; held with its fields until o_ackN.
REQ-007 i_addrN  in  16  port N byte address.
REQ-008 i_wdataN  in  32  port N write data.
REQ-009 i_sizeN  in  2  port N access size: 11 word, 10 half, 00 byte.
REQ-010 i_weN  in  1  port N direction: 1 read, 0 write (active-low write strobe).
REQ-011 o_ackN  out  1  one-cycle completion pulse for port N.
REQ-012 o_rdataN  out  32  port N read data, valid from o_ackN onward.
REQ-013 o_mem_addr, o_mem_wrdata, o_mem_size, o_mem_we  out  16/32/2/1  registered memory-side command; o_mem_we 1 = read, 0 = write.
REQ-014 i_mem_rddata  in  32  memory read data, valid one cycle after o_mem_addr changes.
REQ-015 o_busy  out  1  high in states ACCESS and DONE.
REQ-016 o_owner  out  1  port currently or last granted.

Function
REQ-017 States SHALL be IDLE, ACCESS and DONE.
REQ-018 IDLE: with no request pending, the block SHALL stay in IDLE with o_mem_we=1.
REQ-019 IDLE: on a pending request, the block SHALL select the winner, register its addr, wdata, size and we onto the o_mem_* outputs, set o_owner, and go to ACCESS.
REQ-020 ACCESS: the block SHALL capture i_mem_rddata into o_rdata[owner] (reads only), pulse o_ack[owner]=1, force o_mem_we=1, and go to DONE.
REQ-021 DONE: the block SHALL clear the ack and go to IDLE.
REQ-022 Request inputs SHALL be ignored in ACCESS and DONE.
REQ-023 Latency SHALL be as follows: for a request sampled at edge E0, the ack is high between E1 and E2; each access takes 3 cycles.
REQ-024 Write strobe: o_mem_we=0 SHALL last exactly one cycle (E0 to E1) per write.
REQ-025 On a write, o_rdataN SHALL hold its previous value.
REQ-026 i_sizeN SHALL be forwarded unchanged, including the unused code 01; the block performs no alignment checks.
REQ-027 Round-robin (FIXED_PRI=0): on simultaneous requests, the port not granted last SHALL win; the last-grant pointer resets to 1, so port 0 wins the first tie.
REQ-028 Round-robin: a lone requester SHALL always win, and the pointer then updates to that port.
REQ-029 Fixed priority (FIXED_PRI=1): port 0 SHALL win ties.
REQ-030 A 3-bit starve counter SHALL increment on each port-0 grant made while i_req1 is high.
REQ-031 When the counter equals STARVE_LIMIT and both ports request, port 1 SHALL win and the counter SHALL clear.
REQ-032 The starve counter SHALL also clear on any port-1 grant, and whenever i_req1 is low in IDLE.
REQ-033 A request still high in the IDLE cycle after DONE SHALL be treated as a new request (back-to-back accesses allowed).
REQ-034 At most one o_ackN SHALL be high in any cycle, and never for a port that was not granted.

Reset
REQ-035 While i_rst_n=0, regardless of clock: state=IDLE, o_ack0=o_ack1=0, o_rdata0=o_rdata1=0, o_mem_addr=0, o_mem_wrdata=0, o_mem_size=2'b11, o_mem_we=1, o_busy=0, o_owner=0, last-grant pointer=1, starve counter=0.
REQ-036 Reset asserted mid-access SHALL abort the access with no ack issued and SHALL end any write strobe immediately.

Verification
REQ-037 Single read: p0 read of 0x0100, size 11, memory returns 0xDEADBEEF -> o_ack0 pulses 2 edges after sampling, o_rdata0=0xDEADBEEF, o_ack1 stays 0.
REQ-038 Single write: p1 write of 0x12345678 to 0x0200, size 00 -> o_mem_we=0 for exactly one cycle with o_mem_addr=0x0200 and o_mem_size=00, then o_ack1 pulses and o_rdata1 is unchanged.
REQ-039 Round-robin: both ports hold requests for 4 accesses -> grant order p0,p1,p0,p1, one ack every 3 cycles.
REQ-040 Starvation: FIXED_PRI=1, STARVE_LIMIT=4, both ports requesting continuously -> grant order p0 x4, p1, p0 x4, p1.
REQ-041 Reset mid-write: i_rst_n driven low during ACCESS of a p0 write -> o_mem_we=1 immediately, no o_ack0; after release, p0 (first tie winner) is served normally.
REQ-042 Back-to-back: p0 keeps i_req0 high across its ack with a new address -> the second access starts in the IDLE cycle after DONE, and each acked access is served exactly once.
